// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: tag width, tag count and tag type.
// The status table, reorder buffer and CDB logic use these as well.
package rob_pkg;

   localparam int TAG_W    = 5;
   localparam int NUM_TAGS = 2 ** TAG_W;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [TAG_W:0]   tag_cnt_t;

   localparam tag_cnt_t TAG_CNT_FULL = tag_cnt_t'(NUM_TAGS);

endpackage

// File: rtl/tag_fifo.sv
// Free-list of reorder-buffer tags feeding dispatch.
// This is a circular FIFO that comes out of reset holding every tag (0..NUM_TAGS-1).
// The head tag is presented first-word-fall-through, and tags come back on commit.
module tag_fifo
   import rob_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            alloc_req,
   output tag_t            alloc_tag,
   output logic            alloc_valid,
   input  logic            free_en,
   input  tag_t            free_tag,
   output logic [TAG_W:0]  count,
   output logic            full,
   output logic            empty,
   output logic            overflow_err
);

   tag_t     mem_q [NUM_TAGS];
   tag_t     rd_ptr_q, rd_ptr_d;
   tag_t     wr_ptr_q, wr_ptr_d;
   tag_cnt_t count_q, count_d;
   logic     ovf_q, ovf_d;
   logic     pop, push;

   // Status decode comes from the counter alone.
   // When the FIFO is full or empty, the two pointers are equal, so they cannot tell the cases apart.
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == TAG_CNT_FULL);
      pop   = alloc_req & ~empty;
      // A pop in the same cycle frees a slot, so a free is accepted even when full.
      push  = free_en & (~full | pop);
   end

   assign alloc_tag    = mem_q[rd_ptr_q];
   assign alloc_valid  = ~empty;
   assign count        = count_q;
   assign overflow_err = ovf_q;

   // Next-state logic for the pointers, the counter and the sticky overflow flag.
   // A flush overrides any alloc or free in the same cycle.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = TAG_CNT_FULL;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + tag_t'(1);
         if (push) wr_ptr_d = wr_ptr_q + tag_t'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + tag_cnt_t'(1);
            2'b01:   count_d = count_q - tag_cnt_t'(1);
            default: count_d = count_q;
         endcase
         if (free_en & ~push) ovf_d = 1'b1;
      end
   end

   // Control registers: reset clears everything, while a flush leaves the overflow flag alone.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= TAG_CNT_FULL;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Tag storage is a flop array because reset and flush must restore the identity pattern.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) mem_q[i] <= tag_t'(i);
      end else if (flush) begin
         for (int i = 0; i < NUM_TAGS; i++) mem_q[i] <= tag_t'(i);
      end else if (push) begin
         mem_q[wr_ptr_q] <= free_tag;
      end
   end

endmodule

// File: tb/tb_tag_fifo.sv
// Directed bench for tag_fifo.
// A queue-based model of the free list is checked against the DUT on every falling edge.
// Literal expectations along the directed sequence pin the model itself.
module tb_tag_fifo;
   import rob_pkg::*;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic            alloc_req = 1'b0;
   tag_t            alloc_tag;
   logic            alloc_valid;
   logic            free_en = 1'b0;
   tag_t            free_tag = '0;
   logic [TAG_W:0]  count;
   logic            full;
   logic            empty;
   logic            overflow_err;

   int n_chk = 0;
   int n_err = 0;

   tag_t mq[$];
   bit   m_ovf;
   bit   m_pop, m_push;

   tag_fifo dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .alloc_req    (alloc_req),
      .alloc_tag    (alloc_tag),
      .alloc_valid  (alloc_valid),
      .free_en      (free_en),
      .free_tag     (free_tag),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow_err (overflow_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_fill();
      mq.delete();
      for (int i = 0; i < NUM_TAGS; i++) mq.push_back(tag_t'(i));
   endtask

   // Reference model: the free list is a queue of tags.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_fill();
         m_ovf = 1'b0;
      end else if (flush) begin
         model_fill();
      end else begin
         m_pop  = alloc_req && (mq.size() != 0);
         m_push = free_en && ((mq.size() < NUM_TAGS) || m_pop);
         if (m_pop)  void'(mq.pop_front());
         if (m_push) mq.push_back(free_tag);
         if (free_en && !m_push) m_ovf = 1'b1;
      end
   end

   // Compare the DUT outputs against the model every cycle.
   always @(negedge clock) begin
      if (!reset) begin
         chk("m_count", int'(count), mq.size());
         chk("m_valid", int'(alloc_valid), int'(mq.size() != 0));
         chk("m_full",  int'(full),  int'(mq.size() == NUM_TAGS));
         chk("m_empty", int'(empty), int'(mq.size() == 0));
         chk("m_ovf",   int'(overflow_err), int'(m_ovf));
         if (mq.size() != 0) chk("m_tag", int'(alloc_tag), int'(mq[0]));
      end
   end

   task automatic step(input bit a, input bit f, input int t);
      alloc_req = a;
      free_en   = f;
      free_tag  = tag_t'(t);
      flush     = 1'b0;
      @(posedge clock);
      @(negedge clock);
      alloc_req = 1'b0;
      free_en   = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0;
   endtask

   int exp_seq[8] = '{30, 31, 30, 31, 0, 1, 2, 3};

   initial begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;

      // Reset and idle.
      step(0, 0, 0);
      chk("rst_count", int'(count), 32);
      chk("rst_full",  int'(full), 1);
      chk("rst_valid", int'(alloc_valid), 1);
      chk("rst_tag",   int'(alloc_tag), 0);
      chk("rst_ovf",   int'(overflow_err), 0);

      // Three allocations.
      for (int k = 0; k < 3; k++) begin
         chk("alloc_seq_tag", int'(alloc_tag), k);
         step(1, 0, 0);
      end
      chk("alloc3_tag",   int'(alloc_tag), 3);
      chk("alloc3_count", int'(count), 29);
      chk("alloc3_full",  int'(full), 0);

      // Drain from full.
      do_flush();
      repeat (32) step(1, 0, 0);
      chk("drain_empty", int'(empty), 1);
      chk("drain_valid", int'(alloc_valid), 0);
      chk("drain_count", int'(count), 0);
      step(1, 0, 0);
      chk("drain_ign_count", int'(count), 0);

      // Empty with alloc and free in the same cycle.
      step(1, 1, 7);
      chk("empty_af_count", int'(count), 1);
      chk("empty_af_valid", int'(alloc_valid), 1);
      chk("empty_af_tag",   int'(alloc_tag), 7);

      // Full with alloc and free: both accepted.
      do_flush();
      step(1, 1, 9);
      chk("full_af_ovf",   int'(overflow_err), 0);
      chk("full_af_count", int'(count), 32);
      chk("full_af_tag",   int'(alloc_tag), 1);

      // Full with free only: rejected, sticky error.
      step(0, 1, 9);
      chk("full_f_ovf",   int'(overflow_err), 1);
      chk("full_f_count", int'(count), 32);
      do_flush();
      chk("flush_ovf_held", int'(overflow_err), 1);
      chk("flush_tag",      int'(alloc_tag), 0);

      // Clear the sticky error with reset, then exercise pointer wrap.
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      chk("rst2_ovf", int'(overflow_err), 0);
      repeat (30) step(1, 0, 0);
      for (int k = 0; k < 6; k++) step(0, 1, (30 + k) % 32);
      chk("wrap_count", int'(count), 8);
      for (int k = 0; k < 10; k++) begin
         if (k < 8) chk("wrap_order_tag", int'(alloc_tag), exp_seq[k]);
         step(1, 0, 0);
      end
      chk("wrap_empty", int'(empty), 1);

      // Mixed traffic with a flush in the middle.
      for (int i = 0; i < 80; i++) begin
         if (i == 40) begin
            do_flush();
            chk("mid_flush_count", int'(count), 32);
            chk("mid_flush_tag",   int'(alloc_tag), 0);
         end else begin
            step((i % 3) != 0, (i % 2) == 0, (i * 7) % 32);
         end
      end

      // Asynchronous reset between clock edges.
      repeat (3) step(1, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("async_count", int'(count), 32);
      chk("async_tag",   int'(alloc_tag), 0);
      chk("async_full",  int'(full), 1);
      chk("async_valid", int'(alloc_valid), 1);
      chk("async_empty", int'(empty), 0);
      @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      step(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
- Free-list of reorder-buffer tags for the Tomasulo dispatch path, directly upstream of the register status table.
- Supplies one free tag per cycle to dispatch. That tag is written into the status table as the renamed producer of the destination register.
- Takes tags back when the reorder buffer retires an entry.
- Circular FIFO of 5-bit tags, initialised full (all tags free).

Parameters:
- TAG_W, 5, width of a reorder-buffer tag.
- NUM_TAGS, 32, number of tags and FIFO depth; must equal 2**TAG_W.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous restore to reset contents (branch mispredict / exception recovery).
- alloc_req  input  1  dispatch consumes the head tag this cycle.
- alloc_tag  output  TAG_W  head-of-FIFO tag (first-word fall-through); drives status-table write data.
- alloc_valid  output  1  a free tag is available (FIFO not empty).
- free_en  input  1  return a tag this cycle (reorder-buffer commit).
- free_tag  input  TAG_W  tag being returned.
- count  output  TAG_W+1  number of free tags held, 0..NUM_TAGS.
- full  output  1  count == NUM_TAGS.
- empty  output  1  count == 0.
- overflow_err  output  1  sticky: a free was rejected because the FIFO was full.

Behaviour:
- Storage: mem[NUM_TAGS] of TAG_W bits; rd_ptr and wr_ptr are TAG_W bits and wrap modulo NUM_TAGS naturally; count is a separate register.
- Reset (async) values:
  - mem[i] = i; rd_ptr = 0; wr_ptr = 0; count = NUM_TAGS; overflow_err = 0.
  - Resulting outputs: alloc_tag = 0, alloc_valid = 1, full = 1, empty = 0.
  - Reset asserted mid-operation discards all state immediately, with no waiting for a clock edge.
- flush (sync, priority over alloc/free in the same cycle): same state as reset, except overflow_err is held.
- Outputs alloc_tag = mem[rd_ptr] and alloc_valid = !empty are combinational from registers. There is zero latency from head to output.
- Pop: pop = alloc_req & !empty. On the edge, rd_ptr += 1. An alloc_req while empty is ignored, with no state change.
- Push: push = free_en & (!full | pop). On the edge, mem[wr_ptr] <= free_tag and wr_ptr += 1.
- Simultaneous events:
  - pop & push: count unchanged; both pointers advance.
  - Full with alloc_req and free_en: both are accepted, because the popped slot frees space.
  - Empty with alloc_req and free_en: only the push is accepted. The returned tag appears at alloc_tag on the next cycle, with count = 1.
- count: +1 on push-only, -1 on pop-only, unchanged otherwise; it never exceeds NUM_TAGS or drops below 0.
- Rejected free (free_en & full & !pop): the tag is dropped; overflow_err <= 1 and stays set until reset.
- No duplicate-tag checking; that is the reorder buffer's responsibility.
- Wrap-around: pointer arithmetic is modulo NUM_TAGS, with no special case at index NUM_TAGS-1 -> 0.
- No internal state machine beyond the FIFO; full/empty are decoded from count, never from pointer equality.

Decomposition:
- Shared package rob_pkg: TAG_W, NUM_TAGS, and the tag typedef. These are shared with the status table, reorder buffer, and CDB logic.
- No sub-module. Storage, pointers, and counter all stay in one block; mem is a flop array because it needs a reset-initialised pattern, so no RAM macro is used.

Test Plan:
- Reset, then idle -> count=32, full=1, alloc_valid=1, alloc_tag=0, overflow_err=0.
- alloc_req held 3 cycles -> alloc_tag sequence 0,1,2; then alloc_tag=3, count=29, full=0.
- Drain: alloc_req held 32 cycles -> empty=1, alloc_valid=0, count=0. A further alloc_req is ignored, with rd_ptr unchanged.
- From empty: alloc_req=1 and free_en=1 with free_tag=7 in the same cycle -> count=1. Next cycle alloc_valid=1 and alloc_tag=7.
- Full plus free_en with free_tag=9 and no alloc -> overflow_err=1, count stays 32. With alloc_req=1 the same cycle instead, the push is accepted and overflow_err stays 0.
- Wrap and flush:
  - Allocate 30, free tags 30..35 (mod 32), then allocate 10 -> pointer wrap yields correct FIFO order.
  - flush mid-stream -> count=32, alloc_tag=0.
  - Async reset asserted between clock edges -> outputs return to reset values immediately.
